mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
Parametrised, programmable-modulo up/down counter. It generalises the team's fixed N-bit up counter with direction control, synchronous load and clear, and a runtime modulus. It adds three terminal-count modes: wrap, saturate and one-shot. It is used as the generic timer/event counter in the sequential-logic library, driving downstream FSMs through tc and done.

Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- PRESCALE, 4, enabled cycles per count step; legal range 2..256. Used only when CNT_PRESCALE_EN is defined.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- en  input  1  count enable; one step per enabled cycle.
- clr  input  1  synchronous clear.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- dir  input  1  1 = count up, 0 = count down.
- mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
- max_val  input  WIDTH  upper bound; the count range is 0..max_val.
- count_out  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, 1 cycle wide.
- done  output  1  one-shot completion flag, sticky, registered.

Behaviour:
- Reset (rstn=0, asynchronous): count_out=0, tc=0, done=0, FSM=RUN, prescaler=0.
- All inputs are sampled on the rising edge of clk. Priority per cycle is clr > load > en.
- clr: count_out=0, tc=0, done=0, FSM=RUN, prescaler=0.
- load: count_out = min(load_val, max_val), tc=0, done=0, FSM=RUN, prescaler=0.
- Terminal condition:
  - up: count_out >= max_val. The >= compare covers max_val being lowered below the current count.
  - down: count_out == 0.
- Enabled step in FSM RUN, terminal not met: count_out moves ±1 and tc=0.
- Enabled step in FSM RUN, terminal met: tc=1 for exactly one cycle, then per mode:
  - wrap: up reloads 0; down reloads max_val.
  - saturate: count_out holds. tc pulses again on every further enabled step while still terminal.
  - one-shot: count_out holds, done=1, FSM goes RUN->HALT.
- FSM states:
  - RUN: normal counting.
  - HALT: en is ignored, count_out is frozen, tc=0, done stays 1. Only clr, load or reset return the FSM to RUN.
- en=0: count_out holds, tc=0.
- max_val=0: count_out stays 0. Every enabled step is terminal (tc=1 each step). In one-shot mode the first enabled step halts.
- dir or mode may change on any cycle and take effect on that same edge. A change of mode while in HALT does not leave HALT.
- Latency: count_out and tc update on the edge that samples en. There is no combinational path from inputs to outputs.
- All arithmetic is WIDTH bits, with no carry out. Wrap is handled explicitly, never by natural overflow.

Optional Feature:
CNT_PRESCALE_EN
- Defined: an internal prescaler counts enabled cycles. A count step, including the terminal check and tc, occurs only on every PRESCALE-th enabled cycle. The prescaler resets on rstn, clr, load and at each step. It holds when en=0 and while the FSM is in HALT.
- Not defined: the PRESCALE parameter is unused, and every enabled cycle is a step.

Decomposition:
- Package cnt_pkg holds:
  - typedef enum logic [1:0] cnt_mode_e: CNT_WRAP=2'b00, CNT_SAT=2'b01, CNT_ONESHOT=2'b10, CNT_RSVD=2'b11.
  - typedef enum logic cnt_state_e: CNT_RUN, CNT_HALT.
  - constant CNT_MAX_WIDTH=32.
- Sub-module cnt_prescaler (parameter PRESCALE; ports clk, rstn, clr, en, step) is instantiated only under CNT_PRESCALE_EN.

Test Plan:
All scenarios use WIDTH=4.
- Wrap up: max_val=9, dir=1, mode=00, en=1 for 12 cycles from reset.
  - Required: count 1..9, then 0, 1, 2.
  - Required: tc=1 only on the edge where 9 becomes 0.
- Wrap down with load: load_val=3, then dir=0, en=1 with max_val=5.
  - Required: count 2, 1, 0, 5, 4.
  - Required: tc pulses on the edge where 0 becomes 5.
- Saturate: mode=01, max_val=15, dir=1, load_val=14, then en=1 for 4 cycles.
  - Required: count 15, 15, 15, 15.
  - Required: tc=1 on cycles 2, 3 and 4.
- One-shot: mode=10, dir=0, load_val=2, en=1 for 5 cycles.
  - Required: count 1, 0, 0, 0, 0; done=1 from cycle 3; tc=1 on cycle 3 only.
  - Then clr=1: required count=0, done=0, FSM in RUN.
- Priority and clamp, all in one cycle: clr=1, load=1, en=1. Required: count=0.
- Priority and clamp: load=1 with load_val=12, max_val=7. Required: count=7.
- Priority and clamp: max_val lowered from 15 to 4 while count=10, dir=1, en=1, mode=00. Required: next count=0 with tc=1.
- Async reset mid-count: rstn driven low between clock edges while count=6. Required: count_out=0, tc=0, done=0 immediately, with no clock edge needed.
- With CNT_PRESCALE_EN defined and PRESCALE=4: 8 enabled cycles. Required: count_out=2.

Source files
------------

// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared types and constants for the up/down counter slice
package cnt_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'b00,
    CNT_SAT     = 2'b01,
    CNT_ONESHOT = 2'b10,
    CNT_RSVD    = 2'b11
  } cnt_mode_e;

  typedef enum logic {
    CNT_RUN,
    CNT_HALT
  } cnt_state_e;

  localparam int CNT_MAX_WIDTH = 32;

endpackage

// File: rtl/mod_updown_counter_if.sv
// rtl/mod_updown_counter_if.sv - control/status bundle of the up/down counter
interface mod_updown_counter_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic [1:0]       mode;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] count_out;
  logic             tc;
  logic             done;

  modport master (
    output en, clr, load, load_val, dir, mode, max_val,
    input  count_out, tc, done
  );

  modport slave (
    input  en, clr, load, load_val, dir, mode, max_val,
    output count_out, tc, done
  );

endinterface

// File: rtl/cnt_prescaler.sv
// rtl/cnt_prescaler.sv - enabled-cycle divider producing one step every PRESCALE enables
module cnt_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign step = en && (pre_q == LAST);

  // Advance on each enabled cycle, restart after the step or on clear.
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = step ? '0 : pre_q + PW'(1);
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - programmable-modulo up/down counter (optional CNT_PRESCALE_EN)
module mod_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input logic                clk,
  input logic                rstn,
  mod_updown_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             done_q;
  logic             done_d;
  cnt_state_e       state_q;
  cnt_state_e       state_d;
  cnt_mode_e        mode;
  logic             step;
  logic             terminal;

  assign mode = cnt_mode_e'(bus.mode);

`ifdef CNT_PRESCALE_EN
  // The prescaler only sees enables that could move the counter; HALT freezes it.
  cnt_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rstn (rstn),
    .clr  (bus.clr | bus.load),
    .en   (bus.en & (state_q == CNT_RUN)),
    .step (step)
  );
`else
  logic [8:0] unused_prescale;
  assign unused_prescale = 9'(PRESCALE);
  assign step = 1'b1;
`endif

  // Up uses >= so a max_val lowered below the current count still terminates.
  assign terminal = bus.dir ? (count_q >= bus.max_val) : (count_q == '0);

  // Next-state: clr beats load beats enabled step; HALT ignores en entirely.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    state_d = state_q;
    if (bus.clr) begin
      count_d = '0;
      done_d  = 1'b0;
      state_d = CNT_RUN;
    end else if (bus.load) begin
      count_d = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
      done_d  = 1'b0;
      state_d = CNT_RUN;
    end else if (bus.en && (state_q == CNT_RUN) && step) begin
      if (!terminal) begin
        count_d = bus.dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        case (mode)
          CNT_SAT: begin
            count_d = count_q;
          end
          CNT_ONESHOT: begin
            done_d  = 1'b1;
            state_d = CNT_HALT;
          end
          default: begin
            count_d = bus.dir ? '0 : bus.max_val;
          end
        endcase
      end
    end
  end

  // Counter, flags and FSM registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= CNT_RUN;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign bus.count_out = count_q;
  assign bus.tc        = tc_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - directed table-driven bench for mod_updown_counter
module tb_mod_updown_counter;

  typedef struct {
    string      name;
    logic       clr;
    logic       load;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic [3:0] lv;
    logic [3:0] mx;
    logic [3:0] ec;
    logic       et;
    logic       ed;
  } vec_t;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_fail;
  vec_t vq[$];

  mod_updown_counter_if #(.WIDTH(4)) bus ();

  mod_updown_counter #(
    .WIDTH   (4),
    .PRESCALE(4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic c, input logic l, input logic e,
                     input logic d, input logic [1:0] m, input logic [3:0] lv,
                     input logic [3:0] mx, input logic [3:0] ec, input logic et,
                     input logic ed);
    vec_t v;
    v.name = name; v.clr = c; v.load = l; v.en = e; v.dir = d; v.mode = m;
    v.lv = lv; v.mx = mx; v.ec = ec; v.et = et; v.ed = ed;
    vq.push_back(v);
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic d,
                       input logic [1:0] m, input logic [3:0] lv, input logic [3:0] mx);
    @(negedge clk);
    bus.clr = c; bus.load = l; bus.en = e; bus.dir = d;
    bus.mode = m; bus.load_val = lv; bus.max_val = mx;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    bus.clr = 1'b0; bus.load = 1'b0; bus.en = 1'b0; bus.dir = 1'b1;
    bus.mode = 2'b00; bus.load_val = '0; bus.max_val = 4'd9;

    // wrap up from reset
    for (int i = 1; i <= 9; i++) add("wrap_up", 0, 0, 1, 1, 2'b00, 0, 9, 4'(i), 0, 0);
    add("wrap_up_tc", 0, 0, 1, 1, 2'b00, 0, 9, 0, 1, 0);
    add("wrap_up", 0, 0, 1, 1, 2'b00, 0, 9, 1, 0, 0);
    add("wrap_up", 0, 0, 1, 1, 2'b00, 0, 9, 2, 0, 0);
    // wrap down after load
    add("wd_load", 0, 1, 0, 0, 2'b00, 3, 5, 3, 0, 0);
    add("wrap_dn", 0, 0, 1, 0, 2'b00, 0, 5, 2, 0, 0);
    add("wrap_dn", 0, 0, 1, 0, 2'b00, 0, 5, 1, 0, 0);
    add("wrap_dn", 0, 0, 1, 0, 2'b00, 0, 5, 0, 0, 0);
    add("wrap_dn_tc", 0, 0, 1, 0, 2'b00, 0, 5, 5, 1, 0);
    add("wrap_dn", 0, 0, 1, 0, 2'b00, 0, 5, 4, 0, 0);
    add("en_low_hold", 0, 0, 0, 0, 2'b00, 0, 5, 4, 0, 0);
    // saturate
    add("sat_load", 0, 1, 0, 1, 2'b01, 14, 15, 14, 0, 0);
    add("sat1", 0, 0, 1, 1, 2'b01, 0, 15, 15, 0, 0);
    add("sat2", 0, 0, 1, 1, 2'b01, 0, 15, 15, 1, 0);
    add("sat3", 0, 0, 1, 1, 2'b01, 0, 15, 15, 1, 0);
    add("sat4", 0, 0, 1, 1, 2'b01, 0, 15, 15, 1, 0);
    // one-shot down
    add("os_load", 0, 1, 0, 0, 2'b10, 2, 15, 2, 0, 0);
    add("os1", 0, 0, 1, 0, 2'b10, 0, 15, 1, 0, 0);
    add("os2", 0, 0, 1, 0, 2'b10, 0, 15, 0, 0, 0);
    add("os3", 0, 0, 1, 0, 2'b10, 0, 15, 0, 1, 1);
    add("os4", 0, 0, 1, 0, 2'b10, 0, 15, 0, 0, 1);
    add("os5", 0, 0, 1, 0, 2'b10, 0, 15, 0, 0, 1);
    add("os_halt_up", 0, 0, 1, 1, 2'b10, 0, 15, 0, 0, 1);
    add("os_clr", 1, 0, 0, 1, 2'b10, 0, 15, 0, 0, 0);
    add("os_run_again", 0, 0, 1, 1, 2'b10, 0, 15, 1, 0, 0);
    // priority and clamp
    add("clr_load_en", 1, 1, 1, 1, 2'b00, 5, 15, 0, 0, 0);
    add("load_clamp", 0, 1, 0, 1, 2'b00, 12, 7, 7, 0, 0);
    add("load_en", 0, 1, 1, 1, 2'b00, 10, 15, 10, 0, 0);
    add("max_lowered", 0, 0, 1, 1, 2'b00, 0, 4, 0, 1, 0);
    // max_val = 0
    add("max0_wrap", 0, 0, 1, 1, 2'b00, 0, 0, 0, 1, 0);
    add("max0_wrap", 0, 0, 1, 0, 2'b00, 0, 0, 0, 1, 0);
    add("max0_sat", 0, 0, 1, 1, 2'b01, 0, 0, 0, 1, 0);
    add("max0_os", 0, 0, 1, 1, 2'b10, 0, 0, 0, 1, 1);
    add("max0_os_halt", 0, 0, 1, 1, 2'b10, 0, 0, 0, 0, 1);
    add("halt_mode_chg", 0, 0, 1, 1, 2'b00, 0, 9, 0, 0, 1);
    add("halt_load", 0, 1, 0, 1, 2'b00, 3, 9, 3, 0, 0);
    add("after_halt", 0, 0, 1, 1, 2'b00, 0, 9, 4, 0, 0);

    @(posedge clk);
    #1;
    check("rst_count", 32'(bus.count_out), 0);
    check("rst_tc", 32'(bus.tc), 0);
    check("rst_done", 32'(bus.done), 0);
    @(negedge clk);
    rstn = 1'b1;

`ifdef CNT_PRESCALE_EN
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 1, 2'b00, 0, 15);
    check("prescale_count", 32'(bus.count_out), 2);
`else
    foreach (vq[i]) begin
      drive(vq[i].clr, vq[i].load, vq[i].en, vq[i].dir, vq[i].mode, vq[i].lv, vq[i].mx);
      check({vq[i].name, "_count"}, 32'(bus.count_out), 32'(vq[i].ec));
      check({vq[i].name, "_tc"}, 32'(bus.tc), 32'(vq[i].et));
      check({vq[i].name, "_done"}, 32'(bus.done), 32'(vq[i].ed));
    end
`endif

    // async reset between edges while counting
    drive(0, 1, 0, 1, 2'b00, 5, 9);
    drive(0, 0, 1, 1, 2'b00, 0, 9);
`ifndef CNT_PRESCALE_EN
    check("pre_arst_count", 32'(bus.count_out), 6);
`endif
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_count", 32'(bus.count_out), 0);
    check("arst_tc", 32'(bus.tc), 0);
    check("arst_done", 32'(bus.done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
